// File: rtl/div_acc.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per cycle,
// results registered and held until the next accepted start.
module div_acc #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StartDiv,
  input  logic [WIDTH-1:0] Divident,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Done,
  output logic             Busy,
  output logic             DivByZero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic             dz;

  // {rem, dividend} shifted left by one; the trial difference sign is bit WIDTH+1
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             neg;

  assign shifted = {rem, dvd[WIDTH-1]};
  assign diff    = shifted - {2'b00, dsr};
  assign neg     = diff[WIDTH+1];

  assign Done = (state == S_DONE);
  assign Busy = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      dz        <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (StartDiv) begin
            dvd   <= Divident;
            dsr   <= Divisor;
            rem   <= '0;
            dz    <= (Divisor == '0);
            // a zero divisor runs no iterations, only the finalize cycle
            cnt   <= (Divisor == '0) ? '0 : CNT_W'(WIDTH);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            rem <= neg ? shifted[WIDTH:0] : diff[WIDTH:0];
            dvd <= {dvd[WIDTH-2:0], ~neg};
            cnt <= cnt - 1'b1;
          end else begin
            if (dz) begin
              Quotient  <= '1;
              Remainder <= dvd;
              DivByZero <= 1'b1;
            end else begin
              Quotient  <= dvd;
              Remainder <= rem[WIDTH-1:0];
              DivByZero <= 1'b0;
            end
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_acc.sv
// Scoreboard bench for div_acc: stimulus pushes model results, a monitor
// pops and checks on every Done pulse, including completion latency.
module tb_div_acc;
  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         StartDiv = 1'b0;
  logic [W-1:0] Divident = '0;
  logic [W-1:0] Divisor = '0;
  logic [W-1:0] Quotient, Remainder;
  logic         Done, Busy, DivByZero;

  div_acc #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .StartDiv(StartDiv),
    .Divident(Divident), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder),
    .Done(Done), .Busy(Busy), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero rule.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = W'(int'(a) / int'(b)); e.r = W'(int'(a) % int'(b)); e.dz = 1'b0;
    end
    e.due = 0;
    return e;
  endfunction

  // Monitor
  always @(negedge Clk) begin
    if (Reset && Done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: Done high at cycle %0d with nothing pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(Quotient), 32'(e.q));
        chk("remainder", 32'(Remainder), 32'(e.r));
        chk("divbyzero", 32'(DivByZero), 32'(e.dz));
        chk("done_latency", cyc, e.due);
        chk("busy_in_done", 32'(Busy), 32'd1);
      end
    end
  end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge Clk);
    Divident = a; Divisor = b; StartDiv = 1'b1;
    @(posedge Clk);
    #1;
    e = model(a, b);
    e.due = cyc + ((b == 0) ? 1 : W + 1);
    sb.push_back(e);
    last = e;
    chk("busy_after_start", 32'(Busy), 32'd1);
    @(negedge Clk);
    StartDiv = 1'b0;
    Divident = W'($urandom);
    Divisor  = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: %0d results still pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_held();
    repeat (3) @(negedge Clk);
    chk("held_quotient", 32'(Quotient), 32'(last.q));
    chk("held_remainder", 32'(Remainder), 32'(last.r));
    chk("held_divbyzero", 32'(DivByZero), 32'(last.dz));
    chk("idle_busy", 32'(Busy), 32'd0);
    chk("idle_done", 32'(Done), 32'd0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    start(a, b);
    wait_done();
    check_held();
  endtask

  initial begin
    #1;
    chk("reset_quotient", 32'(Quotient), 32'd0);
    chk("reset_remainder", 32'(Remainder), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_divbyzero", 32'(DivByZero), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    run(16'd20000, 16'd10);
    run(16'hFFFF, 16'd1);
    run(16'hFFFF, 16'hFFFF);
    run(16'd5, 16'd7);
    run(16'd0, 16'd3);
    run(16'd1234, 16'd0);
    run(16'd100, 16'd7);

    // second start while busy must be ignored, operands wiggling meanwhile
    begin
      int n = 0;
      start(16'd1000, 16'd3);
      repeat (4) @(negedge Clk);
      StartDiv = 1'b1; Divident = 16'd9; Divisor = 16'd9;
      while (Done !== 1'b1 && n < 60) begin
        @(negedge Clk);
        Divident = W'($urandom);
        Divisor  = W'($urandom | 1);
        n++;
      end
      StartDiv = 1'b0;
      wait_done();
      repeat (25) @(negedge Clk);
      chk("overlap_quotient", 32'(Quotient), 32'd333);
      chk("overlap_remainder", 32'(Remainder), 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      int mode;
      a = W'($urandom_range(0, 65535));
      mode = $urandom_range(0, 9);
      if (mode == 0)      b = '0;
      else if (mode < 4)  b = W'($urandom_range(1, 15));
      else if (mode < 7)  b = W'($urandom_range(1, 255));
      else                b = W'($urandom_range(1, 65535));
      start(a, b);
      wait_done();
    end

    // establish a non-zero held result, then abort mid-run with reset
    run(16'd999, 16'd10);
    start(16'd500, 16'd4);
    repeat (6) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("abort_quotient", 32'(Quotient), 32'd0);
    chk("abort_remainder", 32'(Remainder), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_divbyzero", 32'(DivByZero), 32'd0);
    sb.delete();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("post_abort_busy", 32'(Busy), 32'd0);
    run(16'd500, 16'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
